vga_sync_decoder: RTL

Receive-side counterpart of the VGA 640x480 timing generator. Samples Hsync/Vsync on the pixel clock and recovers pixel coordinates (x, y) and visible. Checks every sync edge against the expected timing, and declares lock after consistent frames. Used for loopback self-check of the display path and as the front end of any block that consumes a VGA-timed stream.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/sync_edge_detect.sv | 33 +++
 rtl/vga_sync_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants, tracker state encoding and counter helper.
// Imported by both the timing generator and the sync decoder.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_PW_DEF      = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_PW_DEF      = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOT  = H_VISIBLE_DEF + H_FP_DEF + H_PW_DEF + H_BP_DEF;
  localparam int V_TOT  = V_VISIBLE_DEF + V_FP_DEF + V_PW_DEF + V_BP_DEF;
  localparam int HS_ON  = H_VISIBLE_DEF + H_FP_DEF;
  localparam int HS_OFF = HS_ON + H_PW_DEF;
  localparam int VS_ON  = V_VISIBLE_DEF + V_FP_DEF;
  localparam int VS_OFF = VS_ON + V_PW_DEF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  function automatic logic [9:0] wrap_inc(input logic [9:0] val, input logic [9:0] last);
    return (val == last) ? 10'd0 : val + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Edge detector for an active-low sync input; the history flop resets to the
// deasserted level so a sync held low through reset reads as a fresh fall.
module sync_edge_detect
  import vga_timing_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic fall,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next history value is simply the current sample.
  always_comb begin
    prev_d = sync_in;
  end

  // History register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~sync_in;
  assign rise = ~prev_q & sync_in;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from sampled Hsync/Vsync, checks every sync edge
// against the nominal timing and tracks lock across consecutive good frames.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_PW        = H_PW_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_PW        = V_PW_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       err
);

  localparam logic [9:0]  C_H_LAST  = 10'(H_VISIBLE + H_FP + H_PW + H_BP - 1);
  localparam logic [9:0]  C_V_LAST  = 10'(V_VISIBLE + V_FP + V_PW + V_BP - 1);
  localparam logic [9:0]  C_H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0]  C_V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0]  C_HS_ON   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]  C_HS_OFF  = 10'(H_VISIBLE + H_FP + H_PW);
  localparam logic [9:0]  C_VS_ON   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  C_VS_OFF  = 10'(V_VISIBLE + V_FP + V_PW);
  localparam logic [10:0] C_TIMEOUT = 11'(2 * (H_VISIBLE + H_FP + H_PW + H_BP));
  localparam logic [3:0]  C_LOCK    = 4'(LOCK_FRAMES);

  logic hs_fall, hs_rise, vs_fall, vs_rise;
  logic hs_edge, vs_edge, load_h, load_v, hs_mis, vs_mis, mismatch, timeout;
  logic [9:0] x_inc, y_inc, hs_exp, vs_exp;
  state_e state_q, state_d, state_fsm;
  logic [2:0]  good_q, good_d, good_fsm;
  logic [10:0] to_cnt_q, to_cnt_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic visible_q, visible_d, line_start_q, line_start_d;
  logic frame_start_q, frame_start_d, locked_q, locked_d, err_q, err_d;

  sync_edge_detect u_hs_edge (.clk(clk), .rst_n(rst_n), .sync_in(hsync), .fall(hs_fall), .rise(hs_rise));
  sync_edge_detect u_vs_edge (.clk(clk), .rst_n(rst_n), .sync_in(vsync), .fall(vs_fall), .rise(vs_rise));

  // Coordinate tracker: free-run, then snap to the nominal position on a sync edge.
  always_comb begin
    hs_edge  = hs_fall | hs_rise;
    vs_edge  = vs_fall | vs_rise;
    x_inc    = wrap_inc(x_q, C_H_LAST);
    y_inc    = (x_q == C_H_LAST) ? wrap_inc(y_q, C_V_LAST) : y_q;
    hs_exp   = hs_fall ? C_HS_ON : C_HS_OFF;
    vs_exp   = vs_fall ? C_VS_ON : C_VS_OFF;
    hs_mis   = hs_edge && (x_inc != hs_exp);
    // When both syncs move together the column belongs to the hsync rule.
    vs_mis   = vs_edge && ((y_inc != vs_exp) || (!hs_edge && (x_inc != 10'd0)));
    mismatch = hs_mis | vs_mis;
    load_h   = hs_edge && ((state_q != SEARCH) || vs_fall);
    load_v   = vs_edge && ((state_q != SEARCH) || vs_fall);
    x_d      = load_h ? hs_exp : (load_v ? 10'd0 : x_inc);
    y_d      = load_v ? vs_exp : y_inc;
    timeout  = !hs_edge && (to_cnt_q == (C_TIMEOUT - 11'd1));
    to_cnt_d = hs_edge ? 11'd0 : ((to_cnt_q == C_TIMEOUT) ? to_cnt_q : to_cnt_q + 11'd1);
  end

  // Lock state machine and registered output decode.
  always_comb begin
    state_fsm = state_q;
    good_fsm  = good_q;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_fsm = ACQUIRE;
          good_fsm  = 3'd0;
        end else begin
          state_fsm = SEARCH;
        end
      end
      ACQUIRE: begin
        if (mismatch) begin
          good_fsm = 3'd0;
        end else if (vs_fall && (({1'b0, good_q} + 4'd1) >= C_LOCK)) begin
          state_fsm = LOCKED;
        end else if (vs_fall) begin
          good_fsm = good_q + 3'd1;
        end else begin
          good_fsm = good_q;
        end
      end
      LOCKED: begin
        if (mismatch) begin
          state_fsm = ACQUIRE;
          good_fsm  = 3'd0;
        end else begin
          state_fsm = LOCKED;
        end
      end
      default: begin
        state_fsm = SEARCH;
        good_fsm  = 3'd0;
      end
    endcase
    state_d       = timeout ? SEARCH : state_fsm;
    good_d        = timeout ? 3'd0 : good_fsm;
    err_d         = mismatch && (state_q != SEARCH);
    locked_d      = (state_d == LOCKED);
    visible_d     = locked_d && (x_d < C_H_VIS) && (y_d < C_V_VIS);
    line_start_d  = locked_d && (x_d == 10'd0);
    frame_start_d = line_start_d && (y_d == 10'd0);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      good_q        <= 3'd0;
      to_cnt_q      <= 11'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      to_cnt_q      <= to_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign visible     = visible_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule
